// File: rtl/mem_stage_if.sv
// Purpose: bundles the EX->MEM inputs, stall vector, SRAM read word and the MEM->WB / MEM->ID outputs of mem_stage.
// Latency: none; plain signal bundle.
// Backpressure: none here; the stall vector carries all flow control.
// Ports: stall[5:0], ex_to_mem_bus[75:0], ex_load_bus[4:0], data_sram_rdata[31:0] in;
//        mem_to_wb_bus[69:0], mem_to_rf_bus[37:0], mem_adel (only with MEM_MISALIGN_CHK_EN) out.
// master = upstream/driver side, slave = mem_stage.
interface mem_stage_if;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [4:0]  ex_load_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
`ifdef MEM_MISALIGN_CHK_EN
  logic        mem_adel;

  modport master (
    output stall, ex_to_mem_bus, ex_load_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_rf_bus, mem_adel
  );
  modport slave (
    input  stall, ex_to_mem_bus, ex_load_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_rf_bus, mem_adel
  );
`else
  modport master (
    output stall, ex_to_mem_bus, ex_load_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_rf_bus
  );
  modport slave (
    input  stall, ex_to_mem_bus, ex_load_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_rf_bus
  );
`endif
endinterface

// File: rtl/mem_stage.sv
// Purpose: MEM pipeline stage; registers EX->MEM bus, merges SRAM read data, extracts/extends loads, drives WB and ID forwarding buses.
// Latency: one register stage; outputs combinational from the register, SRAM word and hold buffer.
// Backpressure: stall[3] (EX) / stall[4] (MEM); a one-entry hold buffer keeps the SRAM word stable while MEM is stalled.
// Ports: clk, rst (synchronous, active-high), mif (mem_stage_if.slave).
// Optional: define MEM_MISALIGN_CHK_EN to add mem_adel and suppress rf_we on misaligned lh/lhu/lw.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  mif
);

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  logic [75:0] ex_to_mem_r;
  logic [4:0]  load_r;
  logic        hold_v;
  logic [31:0] hold_r;

  // EX stalled while MEM runs: MEM must receive a bubble, not a duplicate.
  logic bubble;
  logic capture;
  assign bubble  = (mif.stall[3] == STOP) && (mif.stall[4] == NO_STOP);
  assign capture = (mif.stall[3] == NO_STOP);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_to_mem_r <= '0;
      load_r      <= '0;
    end else if (capture) begin
      ex_to_mem_r <= mif.ex_to_mem_bus;
      load_r      <= mif.ex_load_bus;
    end
  end

  // The SRAM only presents read data for one cycle; latch it on the first
  // stalled cycle so the output stays put however long the stall lasts.
  // Any register update (reset, bubble, capture) discards the held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v <= 1'b0;
      hold_r <= '0;
    end else if (bubble || capture) begin
      hold_v <= 1'b0;
    end else if ((mif.stall[4] == STOP) && !hold_v) begin
      hold_v <= 1'b1;
      hold_r <= mif.data_sram_rdata;
    end
  end

  // Field decode of the registered EX->MEM bus.
  logic [31:0] mem_pc;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [1:0]  a;
  assign mem_pc     = ex_to_mem_r[75:44];
  assign sel_rf_res = ex_to_mem_r[38];
  assign rf_we      = ex_to_mem_r[37];
  assign rf_waddr   = ex_to_mem_r[36:32];
  assign ex_result  = ex_to_mem_r[31:0];
  assign a          = ex_result[1:0];

  logic ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lw;
  assign {ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lw} = load_r;

  logic [31:0] load_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign load_word = hold_v ? hold_r : mif.data_sram_rdata;
  assign byte_sel  = load_word[{a, 3'b000} +: 8];
  assign half_sel  = a[1] ? load_word[31:16] : load_word[15:0];

  // lw and "no load" both pass the full word through.
  always_comb begin
    load_data = load_word;
    if (ld_lb) begin
      load_data = {{24{byte_sel[7]}}, byte_sel};
    end else if (ld_lbu) begin
      load_data = {24'h0, byte_sel};
    end else if (ld_lh) begin
      load_data = {{16{half_sel[15]}}, half_sel};
    end else if (ld_lhu) begin
      load_data = {16'h0, half_sel};
    end
  end

  logic [31:0] rf_wdata;
  logic        rf_we_out;
  assign rf_wdata = sel_rf_res ? load_data : ex_result;

`ifdef MEM_MISALIGN_CHK_EN
  logic adel;
  assign adel         = ((ld_lh | ld_lhu) & a[0]) | (ld_lw & (a != 2'b00));
  assign mif.mem_adel = adel;
  // A faulting load must not update the register file.
  assign rf_we_out    = rf_we & ~adel;
`else
  assign rf_we_out    = rf_we;
`endif

  assign mif.mem_to_wb_bus = {mem_pc, rf_we_out, rf_waddr, rf_wdata};
  assign mif.mem_to_rf_bus = {rf_we_out, rf_waddr, rf_wdata};

  // data_ram_en/wen and the stall bits of other stages are carried but not
  // consumed here; ld_lw only matters for the misalignment check.
  logic unused_bits;
  assign unused_bits = ^{ex_to_mem_r[43:39], mif.stall[5], mif.stall[2:0], ld_lw};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .mif (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] LB  = 5'b10000;
  localparam logic [4:0] LBU = 5'b01000;
  localparam logic [4:0] LH  = 5'b00100;
  localparam logic [4:0] LHU = 5'b00010;
  localparam logic [4:0] LW  = 5'b00001;

  // Reference model: the instruction currently in MEM and, if MEM has been
  // stalled, the SRAM word frozen on the first stalled cycle.
  logic [75:0] m_bus;
  logic [4:0]  m_load;
  logic [31:0] m_frozen[$];

  logic [69:0] e_wb;
  logic [37:0] e_rf;
  logic        e_adel;

  function automatic logic [75:0] mk(input logic [31:0] pc, input logic sel, input logic we,
                                     input logic [4:0] waddr, input logic [31:0] res);
    return {pc, 1'b1, 4'h0, sel, we, waddr, res};
  endfunction

  // Expected outputs computed with plain arithmetic from the load rules.
  function automatic void model_out();
    logic [31:0] word, res, ld;
    logic        we;
    int          a, v;
    res  = m_bus[31:0];
    a    = int'(res[1:0]);
    word = (m_frozen.size() != 0) ? m_frozen[0] : bus.data_sram_rdata;
    ld   = word;
    if (m_load == LB || m_load == LBU) begin
      v = int'((word >> (8 * a)) & 32'hFF);
      if (m_load == LB && v > 127) v -= 256;
      ld = 32'(v);
    end else if (m_load == LH || m_load == LHU) begin
      v = int'((word >> ((a >= 2) ? 16 : 0)) & 32'hFFFF);
      if (m_load == LH && v > 32767) v -= 65536;
      ld = 32'(v);
    end
    e_adel = ((m_load == LH || m_load == LHU) && (a % 2 == 1)) || (m_load == LW && a != 0);
    we = m_bus[37];
`ifdef MEM_MISALIGN_CHK_EN
    if (e_adel) we = 1'b0;
`else
    e_adel = 1'b0;
`endif
    e_rf = {we, m_bus[36:32], m_bus[38] ? ld : res};
    e_wb = {m_bus[75:44], e_rf};
  endfunction

  // Advance one clock; update the model from the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst || (bus.stall[3] && !bus.stall[4])) begin
      m_bus = '0; m_load = '0; m_frozen.delete();
    end else if (!bus.stall[3]) begin
      m_bus = bus.ex_to_mem_bus; m_load = bus.ex_load_bus; m_frozen.delete();
    end else if (m_frozen.size() == 0) begin
      m_frozen.push_back(bus.data_sram_rdata);
    end
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    model_out();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 6'b0;
    bus.ex_to_mem_bus = mk(32'hBFC0_0000, 1'b1, 1'b1, 5'd9, 32'h1234_5678);
    bus.ex_load_bus = LW;
    bus.data_sram_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    settle();
    total++;
    if (bus.mem_to_wb_bus !== 70'h0) begin
      bad++; $display("FAIL reset_wb: got %h want 0", bus.mem_to_wb_bus);
    end
    total++;
    if (bus.mem_to_rf_bus !== 38'h0) begin
      bad++; $display("FAIL reset_rf: got %h want 0", bus.mem_to_rf_bus);
    end
    total++;
    if (dut.hold_v !== 1'b0) begin
      bad++; $display("FAIL reset_hold_v: got %b want 0", dut.hold_v);
    end
    rst = 1'b0;
    bus.ex_to_mem_bus = '0; bus.ex_load_bus = '0;
    tick();
  endtask

  task automatic test_lw();
    bus.stall = 6'b0;
    bus.ex_to_mem_bus = mk(32'h0000_0100, 1'b1, 1'b1, 5'd5, 32'h0000_1000);
    bus.ex_load_bus = LW;
    bus.data_sram_rdata = 32'h0;
    tick();
    bus.ex_to_mem_bus = '0; bus.ex_load_bus = '0;
    bus.data_sram_rdata = 32'hDEAD_BEEF;
    settle();
    total++;
    if (bus.mem_to_wb_bus[37:0] !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL lw_wb: got %h want %h", bus.mem_to_wb_bus[37:0], {1'b1, 5'd5, 32'hDEAD_BEEF});
    end
    total++;
    if ({bus.mem_to_wb_bus, bus.mem_to_rf_bus} !== {e_wb, e_rf}) begin
      bad++; $display("FAIL lw_model: got %h/%h want %h/%h", bus.mem_to_wb_bus, bus.mem_to_rf_bus, e_wb, e_rf);
    end
  endtask

  // One load through the stage with a given SRAM word; checks against a literal.
  task automatic load_case(input string name, input logic [4:0] ld, input logic [31:0] res,
                           input logic [31:0] word, input logic [31:0] want);
    bus.stall = 6'b0;
    bus.ex_to_mem_bus = mk(32'h0000_0200, 1'b1, 1'b1, 5'd3, res);
    bus.ex_load_bus = ld;
    tick();
    bus.ex_to_mem_bus = '0; bus.ex_load_bus = '0;
    bus.data_sram_rdata = word;
    settle();
    total++;
    if (bus.mem_to_rf_bus[31:0] !== want) begin
      bad++; $display("FAIL %s: got %h want %h", name, bus.mem_to_rf_bus[31:0], want);
    end
    total++;
    if (bus.mem_to_wb_bus !== e_wb) begin
      bad++; $display("FAIL %s_model: got %h want %h", name, bus.mem_to_wb_bus, e_wb);
    end
  endtask

  task automatic test_byte();
    load_case("lb_a3",  LB,  32'h0000_2003, 32'h80FF_7F01, 32'hFFFF_FF80);
    load_case("lbu_a3", LBU, 32'h0000_2003, 32'h80FF_7F01, 32'h0000_0080);
    load_case("lb_a1",  LB,  32'h0000_2001, 32'h80FF_7F01, 32'h0000_007F);
  endtask

  task automatic test_half();
    load_case("lh_a2",  LH,  32'h0000_3002, 32'h8001_7FFE, 32'hFFFF_8001);
    load_case("lhu_a0", LHU, 32'h0000_3000, 32'h8001_7FFE, 32'h0000_7FFE);
  endtask

  task automatic test_hold();
    bus.stall = 6'b0;
    bus.ex_to_mem_bus = mk(32'h0000_0300, 1'b1, 1'b1, 5'd6, 32'h0000_4000);
    bus.ex_load_bus = LW;
    tick();
    // Next instruction waits in EX while MEM is stalled.
    bus.ex_to_mem_bus = mk(32'h0000_0304, 1'b1, 1'b1, 5'd7, 32'h0000_4004);
    bus.ex_load_bus = LW;
    bus.data_sram_rdata = 32'h1234_5678;
    bus.stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++;
      if (bus.mem_to_wb_bus[31:0] !== 32'h1234_5678) begin
        bad++; $display("FAIL hold_cyc%0d: got %h want 12345678", i, bus.mem_to_wb_bus[31:0]);
      end
      tick();
      bus.data_sram_rdata = 32'hAAAA_AAAA;
    end
    bus.stall = 6'b0;
    settle();
    total++;
    if ({bus.mem_to_wb_bus, bus.mem_to_rf_bus} !== {e_wb, e_rf} || e_rf[31:0] !== 32'h1234_5678) begin
      bad++; $display("FAIL hold_release: got %h want %h", bus.mem_to_wb_bus, e_wb);
    end
    tick();
    bus.ex_to_mem_bus = '0; bus.ex_load_bus = '0;
    bus.data_sram_rdata = 32'h0BAD_F00D;
    settle();
    total++;
    if (bus.mem_to_wb_bus[37:0] !== {1'b1, 5'd7, 32'h0BAD_F00D}) begin
      bad++; $display("FAIL hold_next_live: got %h want %h", bus.mem_to_wb_bus[37:0], {1'b1, 5'd7, 32'h0BAD_F00D});
    end
  endtask

  task automatic test_bubble();
    bus.stall = 6'b0;
    bus.ex_to_mem_bus = mk(32'h0000_0400, 1'b1, 1'b1, 5'd8, 32'h0000_5000);
    bus.ex_load_bus = LW;
    bus.data_sram_rdata = 32'h5555_5555;
    tick();
    // EX stalled, MEM free: MEM receives a bubble.
    bus.stall = 6'b001111;
    tick();
    bus.stall = 6'b0;
    bus.ex_to_mem_bus = '0; bus.ex_load_bus = '0;
    settle();
    total++;
    if (bus.mem_to_wb_bus !== 70'h0 || bus.mem_to_rf_bus !== 38'h0) begin
      bad++; $display("FAIL bubble: got %h/%h want 0/0", bus.mem_to_wb_bus, bus.mem_to_rf_bus);
    end
  endtask

`ifdef MEM_MISALIGN_CHK_EN
  task automatic test_misalign();
    bus.stall = 6'b0;
    bus.ex_to_mem_bus = mk(32'h0000_0500, 1'b1, 1'b1, 5'd10, 32'h0000_1002);
    bus.ex_load_bus = LW;
    tick();
    bus.ex_to_mem_bus = '0; bus.ex_load_bus = '0;
    settle();
    total++;
    if (bus.mem_adel !== 1'b1 || bus.mem_to_wb_bus[37] !== 1'b0 || bus.mem_to_rf_bus[37] !== 1'b0) begin
      bad++; $display("FAIL misalign_lw: got adel=%b we=%b/%b want 1 0/0", bus.mem_adel, bus.mem_to_wb_bus[37], bus.mem_to_rf_bus[37]);
    end
  endtask
`endif

  task automatic test_random();
    logic [5:0] stalls [4];
    logic [4:0] loads [6];
    logic [4:0] ld;
    stalls[0] = 6'b000000; stalls[1] = 6'b000111; stalls[2] = 6'b001111; stalls[3] = 6'b011111;
    loads[0] = LB; loads[1] = LBU; loads[2] = LH; loads[3] = LHU; loads[4] = LW; loads[5] = 5'b0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.stall = stalls[$urandom_range(0, 3)];
      ld = loads[$urandom_range(0, 5)];
      bus.ex_load_bus = ld;
      bus.ex_to_mem_bus = {$urandom(), 1'($urandom()), 4'($urandom()), (ld != 5'b0),
                           1'($urandom()), 5'($urandom()), $urandom()};
      bus.data_sram_rdata = $urandom();
      settle();
      total++;
      if ({bus.mem_to_wb_bus, bus.mem_to_rf_bus} !== {e_wb, e_rf}) begin
        bad++; $display("FAIL random_%0d: got %h/%h want %h/%h", i, bus.mem_to_wb_bus, bus.mem_to_rf_bus, e_wb, e_rf);
      end
`ifdef MEM_MISALIGN_CHK_EN
      total++;
      if (bus.mem_adel !== e_adel) begin
        bad++; $display("FAIL random_adel_%0d: got %b want %b", i, bus.mem_adel, e_adel);
      end
`endif
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    m_bus = '0; m_load = '0;
    rst = 1'b1;
    bus.stall = 6'b0;
    bus.ex_to_mem_bus = '0;
    bus.ex_load_bus = '0;
    bus.data_sram_rdata = '0;
    test_reset();
    test_lw();
    test_byte();
    test_half();
    test_hold();
    test_bubble();
`ifdef MEM_MISALIGN_CHK_EN
    test_misalign();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
